// File: rtl/bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter_pkg : shared state encoding and defaults for the CPU bus arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT0 = 3'd1,
    GNT1 = 3'd2,
    ERR0 = 3'd3,
    ERR1 = 3'd4
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 255;

  // Round robin: on a tie the master that did not own the bus last time wins.
  function automatic logic pick_m1(input logic cyc0, input logic cyc1, input logic last);
    return cyc1 && (!cyc0 || !last);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_watchdog.sv
// ----------------------------------------------------------------------------
// bus_watchdog : counts unacked strobed cycles, pulses expire on the last one
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_watchdog
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          waiting;

  assign waiting  = enable_i && stb_i && !ack_i;
  assign expire_o = waiting && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = '0;
    if (waiting && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter : two-master round-robin Wishbone-classic arbiter with watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,

  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,

  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i
);

  arb_state_t state_q;
  logic       last_q;
  logic       s_cyc_q;
  logic       m0_err_q;
  logic       m1_err_q;
  logic       gnt0;
  logic       gnt1;
  logic       expire;

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (gnt0 || gnt1),
    .stb_i    (s_stb_o),
    .ack_i    (s_ack_i),
    .expire_o (expire)
  );

  // Dropping cyc takes precedence over a simultaneous watchdog expiry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      s_cyc_q  <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            s_cyc_q <= 1'b1;
            if (pick_m1(m0_cyc_i, m1_cyc_i, last_q)) begin
              state_q <= GNT1;
              last_q  <= 1'b1;
            end else begin
              state_q <= GNT0;
              last_q  <= 1'b0;
            end
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            state_q <= IDLE;
            s_cyc_q <= 1'b0;
          end else if (expire) begin
            state_q  <= ERR0;
            s_cyc_q  <= 1'b0;
            m0_err_q <= 1'b1;
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            state_q <= IDLE;
            s_cyc_q <= 1'b0;
          end else if (expire) begin
            state_q  <= ERR1;
            s_cyc_q  <= 1'b0;
            m1_err_q <= 1'b1;
          end
        end
        ERR0, ERR1: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          s_cyc_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (gnt0) begin
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (gnt1) begin
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign s_cyc_o  = s_cyc_q;
  assign m0_ack_o = gnt0 && s_ack_i && m0_stb_i;
  assign m1_ack_o = gnt1 && s_ack_i && m1_stb_i;
  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter : directed and random stimulus against a transaction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]    m0_sel, m1_sel;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [31:0]   m0_wdat, m1_wdat;
  logic [31:0]   m0_rdat, m1_rdat;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [3:0]    s_sel;
  logic [AW-1:0] s_adr;
  logic [31:0]   s_wdat, s_rdat;
  logic          s_ack;

  int total = 0;
  int bad   = 0;

  // Model: who owns the bus (-1 none), who is being told err (-1 none),
  // who owned it last, and how many consecutive strobed cycles went unacked.
  int  owner = -1;
  int  errm  = -1;
  int  last  = 1;
  int  waitn = 0;
  bit  model_valid = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb), .m0_we_i (m0_we), .m0_sel_i (m0_sel),
    .m0_adr_i (m0_adr), .m0_dat_i (m0_wdat), .m0_dat_o (m0_rdat),
    .m0_ack_o (m0_ack), .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb), .m1_we_i (m1_we), .m1_sel_i (m1_sel),
    .m1_adr_i (m1_adr), .m1_dat_i (m1_wdat), .m1_dat_o (m1_rdat),
    .m1_ack_o (m1_ack), .m1_err_o (m1_err),
    .s_cyc_o  (s_cyc), .s_stb_o (s_stb), .s_we_o (s_we), .s_sel_o (s_sel),
    .s_adr_o  (s_adr), .s_dat_o (s_wdat), .s_dat_i (s_rdat), .s_ack_i (s_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare this cycle's outputs, then advance the model across the next edge.
  task automatic tick();
    logic [6:0]    e_ctl;
    logic [AW-1:0] e_adr;
    logic [31:0]   e_dat;
    logic [1:0]    e_ack, e_err;
    logic          c[2], st[2];
    c[0] = m0_cyc; c[1] = m1_cyc; st[0] = m0_stb; st[1] = m1_stb;
    @(negedge clk);
    e_ctl = '0; e_adr = '0; e_dat = '0; e_ack = '0; e_err = '0;
    if (owner == 0) begin
      e_ctl = {1'b1, m0_stb, m0_we, m0_sel}; e_adr = m0_adr; e_dat = m0_wdat;
      e_ack[0] = s_ack & m0_stb;
    end else if (owner == 1) begin
      e_ctl = {1'b1, m1_stb, m1_we, m1_sel}; e_adr = m1_adr; e_dat = m1_wdat;
      e_ack[1] = s_ack & m1_stb;
    end else if (errm >= 0) begin
      e_err[errm] = 1'b1;
    end
    if (model_valid) begin
      check("s_ctl", {57'd0, s_cyc, s_stb, s_we, s_sel}, {57'd0, e_ctl});
      check("s_adr", {32'd0, s_adr}, {32'd0, e_adr});
      check("s_wdat", {32'd0, s_wdat}, {32'd0, e_dat});
      check("ack", {62'd0, m1_ack, m0_ack}, {62'd0, e_ack});
      check("err", {62'd0, m1_err, m0_err}, {62'd0, e_err});
      check("m0_rdat", {32'd0, m0_rdat}, {32'd0, s_rdat});
      check("m1_rdat", {32'd0, m1_rdat}, {32'd0, s_rdat});
    end
    if (rst) begin
      owner = -1; errm = -1; last = 1; waitn = 0; model_valid = 1'b1;
    end else if (errm >= 0) begin
      errm = -1;
    end else if (owner < 0) begin
      if (c[0] && c[1]) owner = 1 - last;
      else if (c[0])    owner = 0;
      else if (c[1])    owner = 1;
      if (owner >= 0) begin
        last  = owner;
        waitn = 0;
      end
    end else if (!c[owner]) begin
      owner = -1;
    end else if (st[owner] && !s_ack) begin
      waitn++;
      if (waitn == TO) begin
        errm  = owner;
        owner = -1;
      end
    end else begin
      waitn = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_wdat = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_wdat = 0;
    s_ack = 0; s_rdat = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    do_reset();

    // Single m0 read, acked on the second strobed cycle.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_sel = 4'hF;
    tick();                         // IDLE: request seen
    tick();                         // GNT0, no ack yet
    s_ack = 1; s_rdat = 32'hDEADBEEF;
    tick();                         // ack delivered this cycle
    check("m0_read_data", {32'd0, m0_rdat}, 64'hDEADBEEF);
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    tick();

    // Round-robin tie handling.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    m0_adr = 32'hA0; m1_adr = 32'hB0;
    tick();
    tick();                         // m0 granted first
    m0_cyc = 0; m0_stb = 0;
    tick();                         // m0 released
    tick();                         // dead IDLE cycle, m1 granted
    tick();
    m1_cyc = 0; m1_stb = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();                         // tie again -> m0
    tick();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
    tick();
    tick();
    tick();

    // m1 locked read-modify-write while m0 waits.
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200; m1_sel = 4'hF;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300; s_ack = 1; s_rdat = 32'hCAFEF00D;
    tick();                         // read
    m1_we = 1; m1_wdat = 32'h12345678;
    tick();                         // write
    m1_stb = 0; s_ack = 0;
    tick();
    m1_cyc = 0; m1_we = 0;
    tick();
    tick();
    s_ack = 1;
    tick();                         // m0 finally granted
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    tick();

    // Watchdog expiry, then expiry cycle rescued by ack.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h400;
    for (int i = 0; i < 6; i++) tick();
    check("timeout_err_cleared", {63'd0, m0_err}, 64'd0);
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick();
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 4; i++) tick();
    s_ack = 1;
    tick();                         // would expire, but ack wins
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    tick();

    // Reset in the middle of an m1 cycle, then a tie goes to m0.
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h500;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0; m0_cyc = 1; m0_stb = 1;
    tick();                         // idle after reset, tie seen
    tick();                         // m0 granted
    idle_inputs();
    tick();
    tick();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (m0_cyc) begin
        if ($urandom_range(0, 7) == 0) m0_cyc = 0;
      end else if ($urandom_range(0, 3) == 0) m0_cyc = 1;
      if (m1_cyc) begin
        if ($urandom_range(0, 7) == 0) m1_cyc = 0;
      end else if ($urandom_range(0, 3) == 0) m1_cyc = 1;
      m0_stb  = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb  = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_we   = 1'($urandom);  m1_we   = 1'($urandom);
      m0_sel  = 4'($urandom);  m1_sel  = 4'($urandom);
      m0_adr  = $urandom;      m1_adr  = $urandom;
      m0_wdat = $urandom;      m1_wdat = $urandom;
      s_ack   = ($urandom_range(0, 2) == 0);
      s_rdat  = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
